// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush/halt sequencer for the 5-stage pipeline. Optional
//            performance counters are built when PIPELINE_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             sys_mem,
    input  logic             ex_mispredict,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rw,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    output logic             pc_en,
    output logic             ifid_run,
    output logic             idex_run,
    output logic             exmem_run,
    output logic             memwb_run,
    output logic             ifid_clear,
    output logic             idex_clear,
    output logic             exmem_clear,
    output logic             memwb_clear,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   load_use;
    logic   do_flush;
    logic   do_stall;

    assign load_use = ex_mem_read && (ex_rw != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rw)) ||
                       (id_use_rt && (id_rt == ex_rw)));

    // Actions actually applied in RUN after priority resolution.
    assign do_flush = (state_q == ST_RUN) && !sys_mem && ex_mispredict;
    assign do_stall = (state_q == ST_RUN) && !sys_mem && !ex_mispredict && load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == ST_HALT);

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        ifid_run    = 1'b1;
        idex_run    = 1'b1;
        exmem_run   = 1'b1;
        memwb_run   = 1'b1;
        ifid_clear  = 1'b0;
        idex_clear  = 1'b0;
        exmem_clear = 1'b0;
        memwb_clear = 1'b0;

        if (rst) begin
            state_d     = ST_RUN;
            pc_en       = 1'b0;
            ifid_run    = 1'b0;
            idex_run    = 1'b0;
            exmem_run   = 1'b0;
            memwb_run   = 1'b0;
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
            memwb_clear = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (sys_mem) begin
                        // Syscall retires to WB; the EX instruction is kept in ID/EX.
                        pc_en       = 1'b0;
                        ifid_run    = 1'b0;
                        idex_run    = 1'b0;
                        exmem_clear = 1'b1;
                        memwb_run   = 1'b1;
                        state_d     = ST_HALT;
                    end else if (ex_mispredict) begin
                        ifid_clear = 1'b1;
                        idex_clear = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_run   = 1'b0;
                        idex_clear = 1'b1;
                    end
                end
                ST_HALT: begin
                    pc_en     = 1'b0;
                    ifid_run  = 1'b0;
                    idex_run  = 1'b0;
                    exmem_run = 1'b0;
                    memwb_run = 1'b0;
                    if (go) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPELINE_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_RUN) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (do_stall) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (do_flush) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_actions;
    assign unused_actions = do_flush ^ do_stall;
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed + random self-checking bench for pipeline_ctrl against an
//            action-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst, go, sys_mem, ex_mispredict, ex_mem_read;
    logic [4:0]       ex_rw, id_rs, id_rt;
    logic             id_use_rs, id_use_rt;
    logic             pc_en, ifid_run, idex_run, exmem_run, memwb_run;
    logic             ifid_clear, idex_clear, exmem_clear, memwb_clear;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit               m_halted;
    logic [CNT_W-1:0] m_cycle, m_stall, m_flush;

    typedef enum int { A_RESET, A_FROZEN, A_SYS, A_FLUSH, A_STALL, A_NORMAL } action_t;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .go(go), .sys_mem(sys_mem),
        .ex_mispredict(ex_mispredict), .ex_mem_read(ex_mem_read),
        .ex_rw(ex_rw), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .pc_en(pc_en), .ifid_run(ifid_run), .idex_run(idex_run),
        .exmem_run(exmem_run), .memwb_run(memwb_run),
        .ifid_clear(ifid_clear), .idex_clear(idex_clear),
        .exmem_clear(exmem_clear), .memwb_clear(memwb_clear),
        .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic action_t pick_action();
        bit lu;
        lu = ex_mem_read && (ex_rw != 0) &&
             ((id_use_rs && id_rs == ex_rw) || (id_use_rt && id_rt == ex_rw));
        if (rst)                return A_RESET;
        if (m_halted)           return A_FROZEN;
        if (sys_mem)            return A_SYS;
        if (ex_mispredict)      return A_FLUSH;
        if (lu)                 return A_STALL;
        return A_NORMAL;
    endfunction

    // {pc_en, ifid/idex/exmem/memwb run, ifid/idex/exmem/memwb clear}
    function automatic logic [8:0] expected_ctrl(input action_t a);
        case (a)
            A_RESET:  return 9'b0_0000_1111;
            A_FROZEN: return 9'b0_0000_0000;
            A_SYS:    return 9'b0_0011_0010;
            A_FLUSH:  return 9'b1_1111_1100;
            A_STALL:  return 9'b0_0111_0100;
            default:  return 9'b1_1111_0000;
        endcase
    endfunction

    // Drive one cycle's inputs, check outputs mid-cycle, then advance model on the edge.
    task automatic cycle(input bit r, input bit g, input bit s, input bit mp,
                         input bit mr, input int rw, input int rs, input int rt,
                         input bit urs, input bit urt, input string tag);
        action_t a;
        @(negedge clk);
        rst = r; go = g; sys_mem = s; ex_mispredict = mp; ex_mem_read = mr;
        ex_rw = rw[4:0]; id_rs = rs[4:0]; id_rt = rt[4:0];
        id_use_rs = urs; id_use_rt = urt;
        #1;
        a = pick_action();
        check_eq({tag, ".ctrl"}, {55'd0, pc_en, ifid_run, idex_run, exmem_run, memwb_run,
                                  ifid_clear, idex_clear, exmem_clear, memwb_clear},
                 {55'd0, expected_ctrl(a)});
        check_eq({tag, ".halted"}, {63'd0, halted}, {63'd0, m_halted});
`ifdef PIPELINE_PERF_CNT_EN
        check_eq({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'(m_cycle));
        check_eq({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        check_eq({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`else
        check_eq({tag, ".cnt_tied"}, {cycle_cnt, stall_cnt} | 64'(flush_cnt), 64'd0);
`endif
        @(posedge clk);
        case (a)
            A_RESET:  begin m_halted = 0; m_cycle = '0; m_stall = '0; m_flush = '0; end
            A_FROZEN: if (go) m_halted = 0;
            A_SYS:    begin m_cycle++; m_halted = 1; end
            A_FLUSH:  begin m_cycle++; m_flush++; end
            A_STALL:  begin m_cycle++; m_stall++; end
            default:  m_cycle++;
        endcase
    endtask

    initial begin
        rst = 1; go = 0; sys_mem = 0; ex_mispredict = 0; ex_mem_read = 0;
        ex_rw = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        m_halted = 0; m_cycle = '0; m_stall = '0; m_flush = '0;

        // Reset, then idle
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        // Load-use on rs, then the r0 exception, then on rt
        cycle(0, 0, 0, 0, 1, 5, 5, 0, 1, 0, "lu_rs");
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, "lu_r0");
        cycle(0, 0, 0, 0, 1, 7, 1, 7, 0, 1, "lu_rt");
        cycle(0, 0, 0, 0, 1, 7, 7, 7, 0, 0, "lu_unused");
        // Mispredict wins over load-use
        cycle(0, 0, 0, 1, 1, 5, 5, 0, 1, 0, "mp_lu");
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "after_mp");
        // Syscall halt, frozen for 10 cycles with hazard noise
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "sys");
        for (int i = 0; i < 10; i++)
            cycle(0, 0, 0, i[0], 1, 3, 3, 3, 1, 1, "halt");
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "go");
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "resume");
        // Syscall and mispredict together: freeze wins
        cycle(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, "sys_mp");
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "halt2");
        // Reset while halted
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_halt");
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_reset");

        for (int i = 0; i < 3000; i++) begin
            bit r, g, s;
            r = ($urandom_range(0, 59) == 0);
            g = ($urandom_range(0, 3) == 0);
            s = !m_halted && ($urandom_range(0, 14) == 0);
            cycle(r, g, s, ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
